display_mode_sequencer: RTL and testbench
=========================================

Name: display_mode_sequencer

Overview:
Parametrised display-mode selector for the 7-segment front end. It steps through NUM_MODES display pages (TIME, DATE, ALARM, …) using one-pulse next/prev/home inputs from the debounced keys. It adds idle-timeout return to a home page, optional auto-rotation, and a lock while an edit is in progress. Its mode output drives the display mux; mode_changed_p drives blink/refresh logic.

Parameters:
NUM_MODES, 4, number of display pages; legal range 1..2**MODE_W.
MODE_W, 2, width of mode output.
RESET_MODE, 0, page selected at reset and by home/timeout; must be < NUM_MODES.
TIMEOUT_TICKS, 10, tick_p periods of key inactivity before returning to RESET_MODE; 0 disables timeout.
ROTATE_TICKS, 5, tick_p periods between automatic advances when auto_en=1; 0 disables rotation.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
next_p  in  1  one-cycle pulse: advance one page
prev_p  in  1  one-cycle pulse: go back one page
home_p  in  1  one-cycle pulse: jump to RESET_MODE
tick_p  in  1  one-cycle timebase pulse (1 Hz strobe)
edit_active  in  1  level; 1 freezes the page (time/date set in progress)
auto_en  in  1  level; 1 enables auto-rotation
mode  out  MODE_W  current page index, registered
mode_changed_p  out  1  one-cycle pulse, registered

Behaviour:
- Reset (async, any time, including mid-count): mode=RESET_MODE, mode_changed_p=0, idle and rotate counters=0.
- All inputs are sampled on posedge clk. A pulse sampled at edge n produces the new mode at edge n (visible in cycle n+1). Latency is 1 cycle.
- key = next_p|prev_p|home_p.
- Priority, evaluated per cycle:
  1. edit_active=1: mode held, all pulses ignored, both counters cleared to 0.
  2. home_p: mode<=RESET_MODE.
  3. next_p&prev_p together: no change; still counts as key activity.
  4. next_p: mode<=(mode==NUM_MODES-1)?0:mode+1.
  5. prev_p: mode<=(mode==0)?NUM_MODES-1:mode-1.
  6. Rotate event (auto_en=1): behaves as next_p.
  7. Timeout event (auto_en=0): mode<=RESET_MODE.
- Idle counter:
  - Cleared on any key.
  - Otherwise increments on tick_p and saturates at TIMEOUT_TICKS.
  - Timeout event occurs on the tick_p that makes the count equal TIMEOUT_TICKS, only when mode!=RESET_MODE. The counter then clears.
  - Held at 0 while auto_en=1 or TIMEOUT_TICKS=0.
- Rotate counter:
  - Cleared on any key, or when auto_en=0.
  - Otherwise increments on tick_p.
  - On reaching ROTATE_TICKS: rotate event, counter clears.
  - Never fires when ROTATE_TICKS=0.
- key and tick_p in the same cycle: the key wins, and the counters clear rather than increment.
- Counter width: $clog2(max(TIMEOUT_TICKS,ROTATE_TICKS)+1), minimum 1 bit.
- mode_changed_p:
  - Set for exactly one cycle, coincident with the first cycle a new mode value appears.
  - Only set when the value actually differs. Examples with no pulse: home_p at home, NUM_MODES=1, simultaneous next+prev.
- NUM_MODES=1: mode is constant RESET_MODE.
- With NUM_MODES=2 and both timers disabled, next_p and prev_p each toggle between pages 0 and 1.
- edit_active falling: counting restarts from 0. There is no deferred timeout.

Test Plan:
- Reset and wrap (NUM_MODES=4, RESET_MODE=0): release rst_n → mode=0, mode_changed_p=0. Four next_p → 1,2,3,0, one pulse each. prev_p at 0 → mode=3.
- Home and simultaneous keys: at mode=2, next_p+prev_p → mode stays 2, no pulse. home_p → mode=0, one pulse. home_p again → no pulse.
- Timeout (TIMEOUT_TICKS=3): at mode=2, three tick_p with no key → mode=0 after the 3rd tick. A next_p coinciding with tick 2 restarts the count; the return then needs 3 more ticks.
- Auto-rotate (ROTATE_TICKS=2, auto_en=1): 6 ticks → mode 0→1→2→3, with no timeout return. A prev_p mid-interval clears the rotate count.
- Edit lock: edit_active=1 at mode=1, then next_p, home_p and 20 ticks → mode stays 1, no pulse. Drop edit_active, then 3 ticks (TIMEOUT=3) → mode=0.
- Async reset mid-operation: assert rst_n low between clock edges while the idle count is 2 → mode=RESET_MODE immediately and counters=0. After release, a full TIMEOUT_TICKS is required again.

Source files
------------

// File: rtl/display_mode_sequencer.sv
// rtl/display_mode_sequencer.sv - display page selector with idle timeout, auto-rotate and edit lock
module display_mode_sequencer #(
    parameter int NUM_MODES     = 4,
    parameter int MODE_W        = 2,
    parameter int RESET_MODE    = 0,
    parameter int TIMEOUT_TICKS = 10,
    parameter int ROTATE_TICKS  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_next_p,
    input  logic              i_prev_p,
    input  logic              i_home_p,
    input  logic              i_tick_p,
    input  logic              i_edit_active,
    input  logic              i_auto_en,
    output logic [MODE_W-1:0] o_mode,
    output logic              o_mode_changed_p
);

    localparam int CMAX = (TIMEOUT_TICKS > ROTATE_TICKS) ? TIMEOUT_TICKS : ROTATE_TICKS;
    localparam int CW   = (CMAX < 1) ? 1 : $clog2(CMAX + 1);

    localparam logic [CW-1:0]     TO_LIM = CW'(TIMEOUT_TICKS);
    localparam logic [CW-1:0]     RO_LIM = CW'(ROTATE_TICKS);
    localparam logic [MODE_W-1:0] LAST   = MODE_W'(NUM_MODES - 1);
    localparam logic [MODE_W-1:0] HOME   = MODE_W'(RESET_MODE);
    localparam logic              TO_ON  = (TIMEOUT_TICKS != 0);
    localparam logic              RO_ON  = (ROTATE_TICKS != 0);

    logic [MODE_W-1:0] r_mode;
    logic              r_changed;
    logic [CW-1:0]     r_idle;
    logic [CW-1:0]     r_rot;

    logic              w_key;
    logic              w_to_evt;
    logic              w_rot_evt;
    logic [CW-1:0]     w_idle_inc;
    logic [CW-1:0]     w_rot_inc;
    logic [CW-1:0]     w_idle_nxt;
    logic [CW-1:0]     w_rot_nxt;
    logic [MODE_W-1:0] w_mode_inc;
    logic [MODE_W-1:0] w_mode_dec;
    logic [MODE_W-1:0] w_mode_nxt;

    assign w_key      = i_next_p | i_prev_p | i_home_p;
    assign w_idle_inc = r_idle + 1'b1;
    assign w_rot_inc  = r_rot + 1'b1;
    assign w_mode_inc = (r_mode == LAST) ? '0 : r_mode + 1'b1;
    assign w_mode_dec = (r_mode == '0) ? LAST : r_mode - 1'b1;

    // Idle counter saturates at the limit while already on the home page.
    always_comb begin
        w_idle_nxt = r_idle;
        w_to_evt   = 1'b0;
        if (i_edit_active || w_key || i_auto_en || !TO_ON) begin
            w_idle_nxt = '0;
        end else if (i_tick_p && r_idle != TO_LIM) begin
            if (w_idle_inc == TO_LIM && r_mode != HOME) begin
                w_to_evt   = 1'b1;
                w_idle_nxt = '0;
            end else begin
                w_idle_nxt = w_idle_inc;
            end
        end
    end

    always_comb begin
        w_rot_nxt = r_rot;
        w_rot_evt = 1'b0;
        if (i_edit_active || w_key || !i_auto_en || !RO_ON) begin
            w_rot_nxt = '0;
        end else if (i_tick_p) begin
            if (w_rot_inc == RO_LIM) begin
                w_rot_evt = 1'b1;
                w_rot_nxt = '0;
            end else begin
                w_rot_nxt = w_rot_inc;
            end
        end
    end

    always_comb begin
        w_mode_nxt = r_mode;
        if (i_edit_active) begin
            w_mode_nxt = r_mode;
        end else if (i_home_p) begin
            w_mode_nxt = HOME;
        end else if (i_next_p && i_prev_p) begin
            w_mode_nxt = r_mode;
        end else if (i_next_p || w_rot_evt) begin
            w_mode_nxt = w_mode_inc;
        end else if (i_prev_p) begin
            w_mode_nxt = w_mode_dec;
        end else if (w_to_evt) begin
            w_mode_nxt = HOME;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode    <= HOME;
            r_changed <= 1'b0;
            r_idle    <= '0;
            r_rot     <= '0;
        end else begin
            r_mode    <= w_mode_nxt;
            r_changed <= (w_mode_nxt != r_mode);
            r_idle    <= w_idle_nxt;
            r_rot     <= w_rot_nxt;
        end
    end

    assign o_mode           = r_mode;
    assign o_mode_changed_p = r_changed;

endmodule

// File: tb/tb_display_mode_sequencer.sv
// tb/tb_display_mode_sequencer.sv - directed bench for display_mode_sequencer
module tb_display_mode_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_next_p = 1'b0;
    logic       i_prev_p = 1'b0;
    logic       i_home_p = 1'b0;
    logic       i_tick_p = 1'b0;
    logic       i_edit_active = 1'b0;
    logic       i_auto_en = 1'b0;
    logic [1:0] o_mode;
    logic       o_mode_changed_p;

    int chk = 0;
    int err = 0;

    always #5 clk = ~clk;

    display_mode_sequencer #(
        .NUM_MODES(4), .MODE_W(2), .RESET_MODE(0), .TIMEOUT_TICKS(3), .ROTATE_TICKS(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_next_p(i_next_p), .i_prev_p(i_prev_p), .i_home_p(i_home_p),
        .i_tick_p(i_tick_p), .i_edit_active(i_edit_active), .i_auto_en(i_auto_en),
        .o_mode(o_mode), .o_mode_changed_p(o_mode_changed_p)
    );

    // Drive one cycle of pulses from the falling edge; return 1 ns after the rising edge.
    task automatic step(input logic n, input logic p, input logic h, input logic t);
        @(negedge clk);
        i_next_p = n; i_prev_p = p; i_home_p = h; i_tick_p = t;
        @(posedge clk);
        #1;
        i_next_p = 0; i_prev_p = 0; i_home_p = 0; i_tick_p = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk++;
        if (o_mode !== 2'd0 || o_mode_changed_p !== 1'b0) begin
            err++; $display("FAIL reset mode=%0d chg=%0b expected mode=0 chg=0", o_mode, o_mode_changed_p);
        end
    endtask

    task automatic test_wrap();
        logic [1:0] exp_m [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 0);
            chk++;
            if (o_mode !== exp_m[i] || o_mode_changed_p !== 1'b1) begin
                err++; $display("FAIL wrap_next%0d mode=%0d chg=%0b expected mode=%0d chg=1", i, o_mode, o_mode_changed_p, exp_m[i]);
            end
        end
        step(0, 0, 0, 0);
        chk++;
        if (o_mode_changed_p !== 1'b0) begin
            err++; $display("FAIL wrap_pulse_width chg=%0b expected 0", o_mode_changed_p);
        end
        step(0, 1, 0, 0);
        chk++;
        if (o_mode !== 2'd3 || o_mode_changed_p !== 1'b1) begin
            err++; $display("FAIL wrap_prev mode=%0d chg=%0b expected mode=3 chg=1", o_mode, o_mode_changed_p);
        end
    endtask

    task automatic test_home();
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        chk++;
        if (o_mode !== 2'd2 || o_mode_changed_p !== 1'b0) begin
            err++; $display("FAIL next_prev_both mode=%0d chg=%0b expected mode=2 chg=0", o_mode, o_mode_changed_p);
        end
        step(0, 0, 1, 0);
        chk++;
        if (o_mode !== 2'd0 || o_mode_changed_p !== 1'b1) begin
            err++; $display("FAIL home mode=%0d chg=%0b expected mode=0 chg=1", o_mode, o_mode_changed_p);
        end
        step(0, 0, 1, 0);
        chk++;
        if (o_mode !== 2'd0 || o_mode_changed_p !== 1'b0) begin
            err++; $display("FAIL home_again mode=%0d chg=%0b expected mode=0 chg=0", o_mode, o_mode_changed_p);
        end
    endtask

    task automatic test_timeout();
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk++;
        if (o_mode !== 2'd2) begin
            err++; $display("FAIL timeout_early mode=%0d expected 2", o_mode);
        end
        step(0, 0, 0, 1);
        chk++;
        if (o_mode !== 2'd0 || o_mode_changed_p !== 1'b1) begin
            err++; $display("FAIL timeout_return mode=%0d chg=%0b expected mode=0 chg=1", o_mode, o_mode_changed_p);
        end
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 1);
        step(1, 0, 0, 1);
        chk++;
        if (o_mode !== 2'd3) begin
            err++; $display("FAIL key_with_tick mode=%0d expected 3", o_mode);
        end
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk++;
        if (o_mode !== 2'd3) begin
            err++; $display("FAIL timeout_restart mode=%0d expected 3", o_mode);
        end
        step(0, 0, 0, 1);
        chk++;
        if (o_mode !== 2'd0) begin
            err++; $display("FAIL timeout_after_restart mode=%0d expected 0", o_mode);
        end
    endtask

    task automatic test_rotate();
        logic [1:0] exp_m [6] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3};
        @(negedge clk);
        i_auto_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 1);
            chk++;
            if (o_mode !== exp_m[i]) begin
                err++; $display("FAIL rotate_tick%0d mode=%0d expected %0d", i + 1, o_mode, exp_m[i]);
            end
        end
        step(0, 0, 0, 1);
        step(0, 1, 0, 0);
        step(0, 0, 0, 1);
        chk++;
        if (o_mode !== 2'd2) begin
            err++; $display("FAIL rotate_prev_clears mode=%0d expected 2", o_mode);
        end
        step(0, 0, 0, 1);
        chk++;
        if (o_mode !== 2'd3 || o_mode_changed_p !== 1'b1) begin
            err++; $display("FAIL rotate_after_prev mode=%0d chg=%0b expected mode=3 chg=1", o_mode, o_mode_changed_p);
        end
        @(negedge clk);
        i_auto_en = 1'b0;
    endtask

    task automatic test_edit();
        logic seen_chg;
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        @(negedge clk);
        i_edit_active = 1'b1;
        seen_chg = 1'b0;
        step(1, 0, 0, 0);
        seen_chg |= o_mode_changed_p;
        step(0, 0, 1, 0);
        seen_chg |= o_mode_changed_p;
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0, 1);
            seen_chg |= o_mode_changed_p;
        end
        chk++;
        if (o_mode !== 2'd1 || seen_chg !== 1'b0) begin
            err++; $display("FAIL edit_lock mode=%0d any_chg=%0b expected mode=1 any_chg=0", o_mode, seen_chg);
        end
        @(negedge clk);
        i_edit_active = 1'b0;
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk++;
        if (o_mode !== 2'd1) begin
            err++; $display("FAIL edit_no_deferred mode=%0d expected 1", o_mode);
        end
        step(0, 0, 0, 1);
        chk++;
        if (o_mode !== 2'd0 || o_mode_changed_p !== 1'b1) begin
            err++; $display("FAIL edit_release_timeout mode=%0d chg=%0b expected mode=0 chg=1", o_mode, o_mode_changed_p);
        end
    endtask

    task automatic test_async_reset();
        step(1, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk++;
        if (o_mode !== 2'd0 || o_mode_changed_p !== 1'b0) begin
            err++; $display("FAIL async_reset mode=%0d chg=%0b expected mode=0 chg=0", o_mode, o_mode_changed_p);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk++;
        if (o_mode !== 2'd1) begin
            err++; $display("FAIL reset_full_timeout mode=%0d expected 1", o_mode);
        end
        step(0, 0, 0, 1);
        chk++;
        if (o_mode !== 2'd0) begin
            err++; $display("FAIL reset_timeout_return mode=%0d expected 0", o_mode);
        end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_home();
        test_timeout();
        test_rotate();
        test_edit();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end

endmodule
